// File: rtl/picture_fetch.sv
// Two-stage window fetch: addresses two image ROMs and composites over background.
// Optional build macro: PICTURE_FETCH_BORDER_EN (white 1-pixel ring on the window).
module picture_fetch #(
  parameter int X_POS  = 100,
  parameter int Y_POS  = 100,
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 96
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_bg_in,
  output logic [13:0] rom_addr,
  input  logic [11:0] rom_data1_in,
  input  logic [11:0] rom_data2_in,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out1,
  output logic [11:0] rgb_out2,
  output logic        in_window_out
);

  localparam logic [10:0] XL   = 11'(X_POS);
  localparam logic [10:0] XR   = 11'(X_POS + WIDTH - 1);
  localparam logic [10:0] YT   = 11'(Y_POS);
  localparam logic [10:0] YB   = 11'(Y_POS + HEIGHT - 1);
  localparam logic [13:0] LAST = 14'(WIDTH * HEIGHT - 1);

  logic        hit;
  logic [13:0] cnt;

  logic        hit1;
  logic [10:0] hc1;
  logic [10:0] vc1;
  logic        hs1;
  logic        vs1;
  logic        hb1;
  logic        vb1;
  logic [11:0] bg1;

  logic [11:0] rgb1_n;
  logic [11:0] rgb2_n;

  // Blanked pixels never hit, which also clips an off-screen window.
  assign hit = (hcount_in >= XL) && (hcount_in <= XR) &&
               (vcount_in >= YT) && (vcount_in <= YB) &&
               !hblnk_in && !vblnk_in;

`ifdef PICTURE_FETCH_BORDER_EN
  logic ring;
  logic ring1;

  assign ring = hit && ((hcount_in == XL) || (hcount_in == XR) ||
                        (vcount_in == YT) || (vcount_in == YB));

  // Ring flag travels alongside the stage-1 hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ring1 <= 1'b0;
    else      ring1 <= ring;
  end
`endif

  // Linear pixel counter: cleared every vblank, saturates at the last pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     cnt <= '0;
    else if (vblnk_in)            cnt <= '0;
    else if (hit && cnt != LAST)  cnt <= cnt + 14'd1;
  end

  // Stage 1: register hit, timing, position, background and ROM address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit1     <= 1'b0;
      hc1      <= '0;
      vc1      <= '0;
      hs1      <= 1'b0;
      vs1      <= 1'b0;
      hb1      <= 1'b0;
      vb1      <= 1'b0;
      bg1      <= '0;
      rom_addr <= '0;
    end else begin
      hit1     <= hit;
      hc1      <= hcount_in;
      vc1      <= vcount_in;
      hs1      <= hsync_in;
      vs1      <= vsync_in;
      hb1      <= hblnk_in;
      vb1      <= vblnk_in;
      bg1      <= rgb_bg_in;
      rom_addr <= cnt;
    end
  end

  // Pixel select: blanking wins, then window (ring, ROM), then background.
  always_comb begin
    rgb1_n = bg1;
    rgb2_n = bg1;
    if (hb1 || vb1) begin
      rgb1_n = 12'h000;
      rgb2_n = 12'h000;
    end else if (hit1) begin
      rgb1_n = rom_data1_in;
      rgb2_n = rom_data2_in;
`ifdef PICTURE_FETCH_BORDER_EN
      if (ring1) begin
        rgb1_n = 12'hFFF;
        rgb2_n = 12'hFFF;
      end
`endif
    end
  end

  // Stage 2: register every output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_out    <= '0;
      vcount_out    <= '0;
      hsync_out     <= 1'b0;
      vsync_out     <= 1'b0;
      hblnk_out     <= 1'b0;
      vblnk_out     <= 1'b0;
      rgb_out1      <= '0;
      rgb_out2      <= '0;
      in_window_out <= 1'b0;
    end else begin
      hcount_out    <= hc1;
      vcount_out    <= vc1;
      hsync_out     <= hs1;
      vsync_out     <= vs1;
      hblnk_out     <= hb1;
      vblnk_out     <= vb1;
      rgb_out1      <= rgb1_n;
      rgb_out2      <= rgb2_n;
      in_window_out <= hit1;
    end
  end

endmodule

// File: doc/picture_fetch.md
PICTURE_FETCH -- requirements
Module: picture_fetch

Interface
REQ-001 SHALL provide parameter X_POS, default 100: window left column, in pixels.
REQ-002 SHALL provide parameter Y_POS, default 100: window top row, in pixels.
REQ-003 SHALL provide parameter WIDTH, default 128: window width, in pixels.
REQ-004 SHALL provide parameter HEIGHT, default 96: window height, in pixels.
REQ-005 SHALL provide ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  asynchronous, active-low reset
- hcount_in, vcount_in  in  11  pixel position from VGA timing
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1  VGA timing
- rgb_bg_in  in  12  background pixel
- rom_addr  out  14  shared read address to both image ROMs (synchronous, 1-cycle read)
- rom_data1_in, rom_data2_in  in  12  ROM read data for image 1 and image 2
- hcount_out, vcount_out  out  11  delayed position
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1  delayed timing
- rgb_out1, rgb_out2  out  12  image-1 and image-2 composited pixels, feeding the picture-toggle stage
- in_window_out  out  1  high when the delayed pixel lies inside the window

Function
REQ-006 SHALL define the window inclusively: X_POS <= hcount_in <= X_POS+WIDTH-1 and Y_POS <= vcount_in <= Y_POS+HEIGHT-1, with both blank inputs low.
REQ-007 SHALL use a 2-stage pipeline: stage 1 registers the window hit, timing, position and rgb_bg_in, and drives rom_addr; stage 2 registers all outputs; total latency 2 clk for every output.
REQ-008 SHALL generate rom_addr from a 14-bit counter, not a multiplier: the counter is cleared on any cycle with vblnk_in=1 and increments by 1 after each cycle that hits the window.
REQ-009 rom_addr SHALL equal the counter value presented during the hit cycle, so pixel (X_POS,Y_POS) reads address 0 and pixel (X_POS+WIDTH-1, Y_POS+HEIGHT-1) reads WIDTH*HEIGHT-1.
REQ-010 SHALL hold the counter at WIDTH*HEIGHT-1 rather than wrap if extra hits occur before vblnk (defensive saturation).
REQ-011 SHALL drive rgb_out1=rom_data1_in and rgb_out2=rom_data2_in for an in-window pixel; otherwise both outputs SHALL equal the delayed rgb_bg_in.
REQ-012 SHALL force rgb_out1=rgb_out2=12'h000 when the delayed hblnk or vblnk is 1, overriding REQ-011.
REQ-013 SHALL clip a window that extends past the visible area without error; hits occur only on visible, unblanked pixels.
REQ-014 SHALL let vblnk clearing take priority over increment when both occur in the same cycle.

Reset
REQ-015 While rst=0, SHALL asynchronously clear every output and all pipeline registers to 0 and the address counter to 0.
REQ-016 On release mid-frame, SHALL resume with counter 0; addresses are correct from the next vblnk onward, and images may be misaligned for the remainder of the current frame.

Configuration
REQ-017 With macro PICTURE_FETCH_BORDER_EN defined, SHALL replace both rgb outputs with 12'hFFF on the 1-pixel outer ring of the window (first/last row, first/last column); ROM addressing is unchanged.
REQ-018 Without PICTURE_FETCH_BORDER_EN, border pixels SHALL show ROM data as per REQ-011.

Verification
REQ-019 SHALL cover: reset low mid-frame -> all outputs 0 within the same cycle; after release and the next vblnk, first window pixel reads rom_addr 0.
REQ-020 SHALL cover: hcount=100, vcount=100, unblanked -> rom_addr=0 one clk later; rgb_out1/rgb_out2 = ROM data two clk later, with in_window_out=1.
REQ-021 SHALL cover: pixel (227,195) -> rom_addr=12287; pixel (228,195) -> no increment, and rgb_out1=rgb_out2=rgb_bg_in.
REQ-022 SHALL cover: hblnk_in=1 with rgb_bg_in=12'hABC -> rgb_out1=rgb_out2=12'h000 after 2 clk; hsync_out/vsync_out track the inputs delayed by exactly 2 clk.
REQ-023 SHALL cover: with PICTURE_FETCH_BORDER_EN defined, pixel (100,150) -> 12'hFFF on both outputs, and pixel (101,150) -> ROM data; without the macro, pixel (100,150) -> ROM data.
REQ-024 SHALL cover: forced hit while the counter is at 12287 -> rom_addr stays 12287; vblnk_in=1 in the same cycle -> counter returns to 0.
